// File: rtl/ddr3_req_queue_pkg.sv
// Shared widths, DDR3 address-map positions and FIFO entry layouts for ddr3_req_queue.
package ddr3_req_queue_pkg;

  localparam int unsigned DATA_W       = 128;
  localparam int unsigned MASK_W       = 16;
  localparam int unsigned ID_W         = 16;
  localparam int unsigned BYTE_ADDR_W  = 32;
  localparam int unsigned ADDR_LSB     = 4;
  localparam int unsigned ADDR_FIELD_W = BYTE_ADDR_W - ADDR_LSB;

  localparam int unsigned BANK_LSB     = 11;
  localparam int unsigned BANK_W       = 3;
  localparam int unsigned ROW_LSB      = 14;
  localparam int unsigned ROW_W        = 14;
  localparam int unsigned COL_LSB      = 4;
  localparam int unsigned COL_BURST_W  = 7;
  localparam int unsigned COL_W        = 10;
  localparam int unsigned RANGE_LSB    = 28;
  localparam int unsigned RANGE_W      = 4;

  typedef struct packed {
    logic                    wr;
    logic [MASK_W-1:0]       mask;
    logic [ADDR_FIELD_W-1:0] addr;
    logic [DATA_W-1:0]       data;
    logic [ID_W-1:0]         id;
  } req_entry_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            is_rd;
    logic            err;
  } trk_entry_t;

  localparam int unsigned REQ_ENTRY_W = $bits(req_entry_t);
  localparam int unsigned TRK_ENTRY_W = $bits(trk_entry_t);

  // Address field holds byte address bits [31:4]; helpers rebase the absolute positions.
  function automatic logic [BANK_W-1:0] addr_bank(input logic [ADDR_FIELD_W-1:0] a);
    return a[BANK_LSB-ADDR_LSB +: BANK_W];
  endfunction

  function automatic logic [ROW_W-1:0] addr_row(input logic [ADDR_FIELD_W-1:0] a);
    return a[ROW_LSB-ADDR_LSB +: ROW_W];
  endfunction

  // One BL8 x16 burst covers 16 bytes, so the low three column bits are always zero.
  function automatic logic [COL_W-1:0] addr_col(input logic [ADDR_FIELD_W-1:0] a);
    return {a[COL_LSB-ADDR_LSB +: COL_BURST_W], (COL_W-COL_BURST_W)'(0)};
  endfunction

endpackage

// File: rtl/ddr3_req_queue_fifo.sv
// Generic registered-pointer FIFO with first-word fall-through head and occupancy count.
module ddr3_req_queue_fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out,
  output logic              accept,
  output logic              valid,
  output logic [ADDR_W:0]   count
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign accept   = (count != (ADDR_W+1)'(DEPTH));
  assign valid    = (count != '0);
  assign do_push  = push & accept;
  assign do_pop   = pop & valid;
  assign data_out = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/ddr3_req_queue.sv
// Buffers bridge RAM requests, issues DDR3 commands with read credit, returns in-order completions.
// Optional macro DDR3_REQ_QUEUE_RANGE_CHECK_EN: addresses with bits [31:28] != 0 complete with error.
module ddr3_req_queue
  import ddr3_req_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [MASK_W-1:0]        inport_wr_i,
  input  logic                     inport_rd_i,
  input  logic [BYTE_ADDR_W-1:0]   inport_addr_i,
  input  logic [DATA_W-1:0]        inport_write_data_i,
  input  logic [ID_W-1:0]          inport_req_id_i,
  output logic                     inport_accept_o,
  output logic                     inport_ack_o,
  output logic                     inport_error_o,
  output logic [ID_W-1:0]          inport_resp_id_o,
  output logic [DATA_W-1:0]        inport_read_data_o,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic                     cmd_wr_o,
  output logic [MASK_W-1:0]        cmd_mask_o,
  output logic [BANK_W-1:0]        cmd_bank_o,
  output logic [ROW_W-1:0]         cmd_row_o,
  output logic [COL_W-1:0]         cmd_col_o,
  output logic [DATA_W-1:0]        cmd_wdata_o,
  input  logic                     rd_valid_i,
  input  logic [DATA_W-1:0]        rd_data_i
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned SUM_W = ADDR_W + 2;

  req_entry_t        req_in, req_head;
  trk_entry_t        trk_in, trk_head;
  logic [DATA_W-1:0] rdq_head;
  logic              req_accept, req_valid, req_push, req_pop;
  logic              trk_accept, trk_valid;
  logic              rdq_accept, rdq_valid, rdq_pop;
  logic [CNT_W-1:0]  req_count, trk_count, rdq_count;
  logic [CNT_W-1:0]  rd_outstanding;
  logic              req_w, head_err, credit_ok, issue, err_drop;
  logic              rd_issue, rd_take, cpl_pop;
  logic              unused_sink;

  assign req_w           = inport_rd_i | (|inport_wr_i);
  assign req_push        = req_w & req_accept;
  assign inport_accept_o = req_accept & ~rst_i;

  assign req_in = '{wr:   |inport_wr_i,
                    mask: inport_wr_i,
                    addr: inport_addr_i[ADDR_LSB +: ADDR_FIELD_W],
                    data: inport_write_data_i,
                    id:   inport_req_id_i};

  ddr3_req_queue_fifo #(.WIDTH(REQ_ENTRY_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_req_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push(req_push), .pop(req_pop),
    .data_in(req_in), .data_out(req_head),
    .accept(req_accept), .valid(req_valid), .count(req_count)
  );

`ifdef DDR3_REQ_QUEUE_RANGE_CHECK_EN
  assign head_err = |req_head.addr[RANGE_LSB-ADDR_LSB +: RANGE_W];
`else
  assign head_err = 1'b0;
`endif

  // Data already parked in the read FIFO still occupies credit until it completes.
  assign credit_ok   = ((SUM_W'(rd_outstanding) + SUM_W'(rdq_count)) < SUM_W'(DEPTH));
  assign cmd_valid_o = req_valid & trk_accept & ~head_err & (req_head.wr | credit_ok);
  assign issue       = cmd_valid_o & cmd_ready_i;
  assign err_drop    = req_valid & trk_accept & head_err;
  assign req_pop     = issue | err_drop;
  assign rd_issue    = issue & ~req_head.wr;

  assign trk_in = '{id: req_head.id, is_rd: ~req_head.wr & ~head_err, err: head_err};

  always_comb begin
    cmd_wr_o    = 1'b0;
    cmd_mask_o  = '0;
    cmd_bank_o  = '0;
    cmd_row_o   = '0;
    cmd_col_o   = '0;
    cmd_wdata_o = '0;
    if (cmd_valid_o) begin
      cmd_wr_o    = req_head.wr;
      cmd_mask_o  = req_head.mask;
      cmd_bank_o  = addr_bank(req_head.addr);
      cmd_row_o   = addr_row(req_head.addr);
      cmd_col_o   = addr_col(req_head.addr);
      cmd_wdata_o = req_head.data;
    end
  end

  ddr3_req_queue_fifo #(.WIDTH(TRK_ENTRY_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_trk_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push(req_pop), .pop(cpl_pop),
    .data_in(trk_in), .data_out(trk_head),
    .accept(trk_accept), .valid(trk_valid), .count(trk_count)
  );

  // Stray read data with nothing outstanding is a core protocol violation and is dropped.
  assign rd_take = rd_valid_i & (rd_outstanding != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_outstanding <= '0;
    end else begin
      case ({rd_issue, rd_take})
        2'b10:   rd_outstanding <= rd_outstanding + CNT_W'(1);
        2'b01:   rd_outstanding <= rd_outstanding - CNT_W'(1);
        default: rd_outstanding <= rd_outstanding;
      endcase
    end
  end

  ddr3_req_queue_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rdq_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push(rd_take), .pop(rdq_pop),
    .data_in(rd_data_i), .data_out(rdq_head),
    .accept(rdq_accept), .valid(rdq_valid), .count(rdq_count)
  );

  assign cpl_pop = trk_valid & (~trk_head.is_rd | rdq_valid);
  assign rdq_pop = cpl_pop & trk_head.is_rd;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inport_ack_o       <= 1'b0;
      inport_resp_id_o   <= '0;
      inport_read_data_o <= '0;
    end else begin
      inport_ack_o       <= cpl_pop;
      inport_resp_id_o   <= cpl_pop ? trk_head.id : '0;
      inport_read_data_o <= rdq_pop ? rdq_head : '0;
    end
  end

`ifdef DDR3_REQ_QUEUE_RANGE_CHECK_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) inport_error_o <= 1'b0;
    else       inport_error_o <= cpl_pop & trk_head.err;
  end
`else
  assign inport_error_o = 1'b0;
`endif

  // Bits deliberately not consumed in every build configuration.
  assign unused_sink = ^{inport_addr_i[ADDR_LSB-1:0], req_head.addr[RANGE_LSB-ADDR_LSB +: RANGE_W],
                         trk_head.err, req_count, trk_count, rdq_accept};

endmodule

// File: doc/ddr3_req_queue.md
Name: ddr3_req_queue

Overview:
- Downstream neighbour of the AXI-to-RAM bridge. Accepts its 128-bit RAM request stream (wr strobes / rd / addr / data / 16-bit req id) and buffers it in a request FIFO.
- Decodes each address into DDR3 bank/row/column and issues commands to the DDR3 core with a valid/ready handshake.
- Returns in-order completions (ack + resp id + read data) to the bridge. Read-data returns from the core have no backpressure, so the block holds enough credit to absorb every outstanding read.

Parameters:
DEPTH, 4, entries in the request FIFO, the tracking FIFO and the read-data FIFO (power of two, 2..16)
ADDR_W, 2, log2(DEPTH)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
inport_wr_i  in  16  byte write strobes; non-zero = write request
inport_rd_i  in  1  read request (never asserted together with non-zero inport_wr_i)
inport_addr_i  in  32  byte address, bits [3:0] ignored
inport_write_data_i  in  128  write data
inport_req_id_i  in  16  request tag, returned unchanged
inport_accept_o  out  1  request taken this cycle
inport_ack_o  out  1  single-cycle completion pulse, no backpressure
inport_error_o  out  1  completion error flag, valid with ack
inport_resp_id_o  out  16  tag of the completing request
inport_read_data_o  out  128  read data, valid with ack of a read
cmd_valid_o  out  1  command valid to the DDR3 core
cmd_ready_i  in  1  core accepts command
cmd_wr_o  out  1  1 = write, 0 = read
cmd_mask_o  out  16  byte enables (write)
cmd_bank_o  out  3  bank
cmd_row_o  out  14  row
cmd_col_o  out  10  column
cmd_wdata_o  out  128  write data
rd_valid_i  in  1  read data returned by core, in issue order
rd_data_i  in  128  read data

Behaviour:
- Request valid: req_w = inport_rd_i | (|inport_wr_i).
- inport_accept_o = request FIFO not full (independent of req_w). Push when req_w & accept.
- Request FIFO entry: {wr, mask, addr[31:4], data, id}.
- Decode, combinational from the FIFO head:
  - bank = addr[13:11]
  - row = addr[27:14]
  - col = {addr[10:4], 3'b000} (one BL8 x16 burst = 16 bytes)
- cmd_valid_o = FIFO head valid & tracking FIFO not full & (head is write | read credit available). Command outputs are driven from the head; they are zero when cmd_valid_o = 0.
- Issue: cmd_valid_o & cmd_ready_i pops the head and pushes {id, is_rd} into the tracking FIFO.
- Read credit: rd_outstanding counter (ADDR_W+1 bits).
  - Increments on read issue; decrements on rd_valid_i; on simultaneous events it is unchanged.
  - Credit available iff rd_outstanding + rd-data-FIFO count < DEPTH.
  - Under this rule rd_valid_i never overflows the read-data FIFO. rd_valid_i with rd_outstanding = 0 is a core protocol violation: the data is dropped and the counter is held at 0.
- Completion, at most one per cycle, from the tracking FIFO head:
  - Head is a write: completes the cycle after it becomes head, or the same cycle if it was already head.
  - Head is a read: completes when the read-data FIFO is non-empty; pops both FIFOs.
  - Completion outputs are registered: inport_ack_o pulses one cycle after the pop condition. resp_id and read_data are valid in the same cycle as the ack; read_data = 0 for writes.
- Ordering: completions strictly in acceptance order.
- Simultaneous push/pop on any FIFO in the same cycle: count unchanged, both operations take effect. Pointers wrap modulo DEPTH.
- Reset, including mid-operation: all FIFOs emptied, counters 0, all outputs 0. In-flight core reads are discarded; the core is reset together with this block.

Optional Feature:
- Macro: DDR3_REQ_QUEUE_RANGE_CHECK_EN.
- Defined:
  - A request with addr[31:28] != 0 is still accepted and queued.
  - At the head it is popped without issuing to the core; {id, err} is pushed into the tracking FIFO.
  - Its completion asserts inport_error_o = 1, read_data = 0.
- Undefined: addr[31:28] is ignored; inport_error_o is tied to 0.

Decomposition:
- Package ddr3_req_queue_pkg: localparams for bank/row/column bit positions and widths, and the request and tracking FIFO entry widths.
- One sub-module, ddr3_req_queue_fifo: generic registered-pointer FIFO with push/pop/accept/valid/count outputs, instantiated three times (request, tracking, read data).

Test Plan:
- Single write: addr 0x0000_3810, mask 0xFFFF, id 0x1234, cmd_ready_i = 1. Required: cmd issued with bank 7, row 0, col 0x008, wr = 1; ack pulse with resp_id 0x1234, read_data 0.
- Read then write: read id 0x0011, then write id 0x0022; hold rd_valid_i low for 5 cycles. Required: write ack waits; acks arrive in order 0x0011 (data = rd_data_i) then 0x0022.
- Credit limit (DEPTH = 4): push 6 reads with rd_valid_i held low. Required: exactly 4 reads issued; the 5th is issued only after the first rd_valid_i.
- Backpressure: cmd_ready_i = 0 while pushing. Required: inport_accept_o drops after 4 requests; no loss or duplication after release.
- Reset mid-operation: assert rst_i with 3 requests queued. Required: all outputs 0, accept = 1 after release, no stale acks.
- DDR3_REQ_QUEUE_RANGE_CHECK_EN defined: read at 0x1000_0000. Required: no cmd_valid_o; ack with inport_error_o = 1.
